// File: rtl/magnitude_compare_seq_if.sv
// Purpose: handshake and operand/result bundle for the sequenced magnitude comparator.
// Latency: none (signal bundle only).
// Backpressure: start is honoured only while the comparator reports busy low.
interface magnitude_compare_seq_if #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
);
    localparam int NSLICE = WIDTH / CHUNK;
    localparam int CW     = $clog2(NSLICE) + 1;

    logic              start;
    logic [WIDTH-1:0]  x1;
    logic [WIDTH-1:0]  x2;
    logic              busy;
    logic              done;
    logic              L;
    logic              E;
    logic              G;
    logic [CW-1:0]     cycles;

    // Requester side: issues compares and consumes the result.
    modport master (
        output start, x1, x2,
        input  busy, done, L, E, G, cycles
    );

    // Comparator side.
    modport slave (
        input  start, x1, x2,
        output busy, done, L, E, G, cycles
    );
endinterface

// File: rtl/magnitude_compare_seq.sv
// Purpose: unsigned magnitude compare of two WIDTH-bit operands, CHUNK bits per clock, MSB-first with early exit.
// Latency: start edge + k COMPARE cycles (1..NSLICE); done pulses in cycle k+1, results hold until the next accept.
// Backpressure: start is ignored while busy (COMPARE and DONE); nothing is queued.
module magnitude_compare_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    magnitude_compare_seq_if.slave  bus
);
    // WIDTH must be a multiple of CHUNK; NSLICE is derived and fixed.
    localparam int NSLICE = WIDTH / CHUNK;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int CW     = $clog2(NSLICE) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a1;
    logic [WIDTH-1:0]   r_a2;
    logic [IDXW-1:0]    r_idx;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_l;
    logic               r_e;
    logic               r_g;
    logic [CW-1:0]      r_cycles;

    logic [CHUNK-1:0]   w_s1;
    logic [CHUNK-1:0]   w_s2;
    logic [WIDTH-1:0]   w_a1_nxt;
    logic [WIDTH-1:0]   w_a2_nxt;

    // The operands are shifted left as slices are consumed, so the slice
    // under test is always the top CHUNK bits: a constant part-select keeps
    // the per-cycle compare path short and avoids a variable-index mux.
    assign w_s1 = r_a1[WIDTH-1 -: CHUNK];
    assign w_s2 = r_a2[WIDTH-1 -: CHUNK];

    generate
        if (NSLICE > 1) begin : g_shift
            assign w_a1_nxt = {r_a1[WIDTH-CHUNK-1:0], {CHUNK{1'b0}}};
            assign w_a2_nxt = {r_a2[WIDTH-CHUNK-1:0], {CHUNK{1'b0}}};
        end else begin : g_single
            // One slice only: the first compare always terminates.
            assign w_a1_nxt = r_a1;
            assign w_a2_nxt = r_a2;
        end
    endgenerate

    // Controller: accept in IDLE, walk slices MSB-first, publish a registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a1     <= '0;
            r_a2     <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_l      <= 1'b0;
            r_e      <= 1'b0;
            r_g      <= 1'b0;
            r_cycles <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a1    <= bus.x1;
                        r_a2    <= bus.x2;
                        r_idx   <= IDXW'(NSLICE - 1);
                        r_cnt   <= '0;
                        r_l     <= 1'b0;
                        r_e     <= 1'b0;
                        r_g     <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (w_s1 > w_s2) begin
                        r_g      <= 1'b1;
                        r_l      <= 1'b0;
                        r_e      <= 1'b0;
                        r_cycles <= r_cnt + CW'(1);
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (w_s1 < w_s2) begin
                        r_l      <= 1'b1;
                        r_g      <= 1'b0;
                        r_e      <= 1'b0;
                        r_cycles <= r_cnt + CW'(1);
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (r_idx == '0) begin
                        r_e      <= 1'b1;
                        r_l      <= 1'b0;
                        r_g      <= 1'b0;
                        r_cycles <= CW'(NSLICE);
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_idx <= r_idx - IDXW'(1);
                        r_cnt <= r_cnt + CW'(1);
                        r_a1  <= w_a1_nxt;
                        r_a2  <= w_a2_nxt;
                    end
                end
                S_DONE: begin
                    // busy covers the done cycle so a held start cannot be
                    // accepted until the cycle after done.
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.L      = r_l;
    assign bus.E      = r_e;
    assign bus.G      = r_g;
    assign bus.cycles = r_cycles;
endmodule

// File: tb/tb_magnitude_compare_seq.sv
// Purpose: scoreboard bench for magnitude_compare_seq at CHUNK=4, 1 and 32 (WIDTH=32).
// Latency: expectations are queued at start and retired on each done pulse.
// Backpressure: start is toggled while busy to confirm it is ignored.
module tb_magnitude_compare_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    magnitude_compare_seq_if #(.WIDTH(32), .CHUNK(4))  if_d ();
    magnitude_compare_seq_if #(.WIDTH(32), .CHUNK(1))  if_b ();
    magnitude_compare_seq_if #(.WIDTH(32), .CHUNK(32)) if_w ();

    magnitude_compare_seq #(.WIDTH(32), .CHUNK(4))  u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));
    magnitude_compare_seq #(.WIDTH(32), .CHUNK(1))  u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    magnitude_compare_seq #(.WIDTH(32), .CHUNK(32)) u_w (.clk(clk), .rst_n(rst_n), .bus(if_w));

    typedef struct packed {
        logic        l;
        logic        e;
        logic        g;
        logic [31:0] cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int chunk_of(input int s);
        case (s)
            0:       return 4;
            1:       return 1;
            default: return 32;
        endcase
    endfunction

    // Reference: number of slices examined MSB-first until the first difference.
    function automatic int model_cyc(input logic [31:0] a, input logic [31:0] b, input int chunk);
        int          ns;
        logic [63:0] m;
        logic [63:0] aa;
        logic [63:0] bb;
        ns = 32 / chunk;
        m  = (64'd1 << chunk) - 64'd1;
        for (int i = ns - 1; i >= 0; i--) begin
            aa = ({32'd0, a} >> (i * chunk)) & m;
            bb = ({32'd0, b} >> (i * chunk)) & m;
            if (aa != bb) return ns - i;
        end
        return ns;
    endfunction

    function automatic exp_t make_exp(input int s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.l   = (a < b);
        e.e   = (a == b);
        e.g   = (a > b);
        e.cyc = 32'(model_cyc(a, b, chunk_of(s)));
        return e;
    endfunction

    task automatic push_exp(input int s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            0:       q0.push_back(make_exp(s, a, b));
            1:       q1.push_back(make_exp(s, a, b));
            default: q2.push_back(make_exp(s, a, b));
        endcase
    endtask

    task automatic drive(input int s, input logic st, input logic [31:0] a, input logic [31:0] b);
        case (s)
            0:       begin if_d.start = st; if_d.x1 = a; if_d.x2 = b; end
            1:       begin if_b.start = st; if_b.x1 = a; if_b.x2 = b; end
            default: begin if_w.start = st; if_w.x1 = a; if_w.x2 = b; end
        endcase
    endtask

    function automatic logic get_done(input int s);
        case (s)
            0:       return if_d.done;
            1:       return if_b.done;
            default: return if_w.done;
        endcase
    endfunction

    function automatic logic get_busy(input int s);
        case (s)
            0:       return if_d.busy;
            1:       return if_b.busy;
            default: return if_w.busy;
        endcase
    endfunction

    function automatic logic [2:0] get_leg(input int s);
        case (s)
            0:       return {if_d.L, if_d.E, if_d.G};
            1:       return {if_b.L, if_b.E, if_b.G};
            default: return {if_w.L, if_w.E, if_w.G};
        endcase
    endfunction

    function automatic logic [31:0] get_cyc(input int s);
        case (s)
            0:       return 32'(if_d.cycles);
            1:       return 32'(if_b.cycles);
            default: return 32'(if_w.cycles);
        endcase
    endfunction

    function automatic int qsize(input int s);
        case (s)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic score(input int s);
        exp_t e;
        if (qsize(s) == 0) begin
            chk($sformatf("s%0d_unexpected_done", s), 32'd1, 32'd0);
        end else begin
            case (s)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("s%0d_LEG", s), 32'(get_leg(s)), 32'({e.l, e.e, e.g}));
            chk($sformatf("s%0d_cycles", s), get_cyc(s), e.cyc);
        end
    endtask

    // Retire one expectation per done pulse on every DUT.
    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (get_done(s) === 1'b1) score(s);
        end
    end

    // One full compare with random start/operand noise while busy.
    task automatic run_cmp(input int s, input logic [31:0] a, input logic [31:0] b);
        int       k;
        int       n;
        logic     got;
        exp_t     e;
        k = model_cyc(a, b, chunk_of(s));
        e = make_exp(s, a, b);
        @(negedge clk);
        drive(s, 1'b1, a, b);
        push_exp(s, a, b);
        n   = 0;
        got = 1'b0;
        while (!got && n < k + 4) begin
            @(negedge clk);
            n++;
            got = get_done(s);
            if (n == 1) begin
                chk($sformatf("s%0d_leg_cleared", s), 32'(get_leg(s)), 32'd0);
                chk($sformatf("s%0d_busy_compare", s), 32'(get_busy(s)), 32'd1);
            end
            drive(s, got ? 1'b0 : 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
        chk($sformatf("s%0d_latency", s), 32'(n), 32'(k + 1));
        chk($sformatf("s%0d_busy_in_done", s), 32'(get_busy(s)), 32'd1);
        @(negedge clk);
        chk($sformatf("s%0d_busy_idle", s), 32'(get_busy(s)), 32'd0);
        chk($sformatf("s%0d_done_pulse", s), 32'(get_done(s)), 32'd0);
        chk($sformatf("s%0d_hold", s), 32'(get_leg(s)), 32'({e.l, e.e, e.g}));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          k0;
        int          k1;
        logic        saw_done;

        for (int s = 0; s < 3; s++) drive(s, 1'b0, 32'd0, 32'd0);

        // Reset state on all three configurations.
        #2 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("s%0d_rst_busy", s), 32'(get_busy(s)), 32'd0);
            chk($sformatf("s%0d_rst_done", s), 32'(get_done(s)), 32'd0);
            chk($sformatf("s%0d_rst_leg", s), 32'(get_leg(s)), 32'd0);
            chk($sformatf("s%0d_rst_cycles", s), get_cyc(s), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed compares on the default configuration.
        run_cmp(0, 32'hDEADBEEF, 32'hDEADBEEF);
        run_cmp(0, 32'h8000_0000, 32'h7FFF_FFFF);
        run_cmp(0, 32'h1234_5670, 32'h1234_5671);
        run_cmp(0, 32'h0000_0100, 32'h0000_00FF);

        // start held high: only operands present in IDLE are latched.
        a  = 32'h1234_5678; b = 32'h1230_5678;
        k0 = model_cyc(a, b, 4);
        @(negedge clk);
        drive(0, 1'b1, a, b);
        push_exp(0, a, b);
        for (int n = 1; n <= k0 + 1; n++) begin
            @(negedge clk);
            chk("held_busy0", 32'(get_busy(0)), 32'd1);
            if (n == k0 + 1) chk("held_done0", 32'(get_done(0)), 32'd1);
            drive(0, 1'b1, $urandom, $urandom);
        end
        @(negedge clk);
        chk("held_idle_gap", 32'(get_busy(0)), 32'd0);
        a  = 32'h0000_0100; b = 32'h0000_00FF;
        k1 = model_cyc(a, b, 4);
        drive(0, 1'b1, a, b);
        push_exp(0, a, b);
        for (int n = 1; n <= k1 + 1; n++) begin
            @(negedge clk);
            chk("held_busy1", 32'(get_busy(0)), 32'd1);
            if (n == k1 + 1) chk("held_done1", 32'(get_done(0)), 32'd1);
            drive(0, (n == k1 + 1) ? 1'b0 : 1'b1, $urandom, $urandom);
        end
        @(negedge clk);
        chk("held_queue_drained", 32'(qsize(0)), 32'd0);

        // Reset during the 4th COMPARE cycle aborts with no result.
        @(negedge clk);
        drive(0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            drive(0, 1'b0, $urandom, $urandom);
        end
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(get_busy(0)), 32'd0);
        chk("abort_done", 32'(get_done(0)), 32'd0);
        chk("abort_leg", 32'(get_leg(0)), 32'd0);
        chk("abort_cycles", get_cyc(0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (get_done(0) === 1'b1) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        run_cmp(0, 32'd5, 32'd5);

        // Random sweeps, biased towards equal and near-equal operands.
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < ((s == 0) ? 200 : 1000); i++) begin
                a = $urandom;
                case ($urandom_range(0, 2))
                    0:       b = $urandom;
                    1:       b = a;
                    default: b = a ^ (32'd1 << $urandom_range(0, 31));
                endcase
                run_cmp(s, a, b);
            end
        end

        @(negedge clk);
        chk("queues_empty", 32'(qsize(0) + qsize(1) + qsize(2)), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
